// File: rtl/dynamixel_pkg.sv
// Shared Dynamixel Protocol 2.0 definitions: framing constants, parser
// state encoding and the CRC-16 byte update used by the transmitters too.
package dynamixel_pkg;

    localparam logic [7:0] HDR1            = 8'hFF;
    localparam logic [7:0] HDR2            = 8'hFF;
    localparam logic [7:0] HDR3            = 8'hFD;
    localparam logic [7:0] RSV             = 8'h00;
    localparam logic [7:0] INST_STATUS     = 8'h55;
    localparam logic [7:0] INST_SYNC_WRITE = 8'h83;

    localparam logic [15:0] CRC_POLY = 16'h8005;

    // Status packet parser states, in packet byte order.
    typedef enum logic [3:0] {
        ST_H1,
        ST_H2,
        ST_H3,
        ST_RSV,
        ST_ID,
        ST_LEN_L,
        ST_LEN_H,
        ST_INSTR,
        ST_ERR,
        ST_PARAM,
        ST_CRC_L,
        ST_CRC_H
    } rx_state_e;

    // CRC-16 (poly 0x8005, no reflection), one byte folded in MSB first.
    function automatic logic [15:0] crc16(input logic [15:0] crc_in,
                                          input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dynamixel_crc16.sv
// Per-byte CRC-16 accumulator. clear alone zeroes the register; clear
// together with enable restarts the CRC from zero with data_in folded in,
// so a header hunt can restart on a fresh FF without losing that byte.
module dynamixel_crc16
    import dynamixel_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data_in,
    output logic [15:0] crc
);

    logic [15:0] crc_d;
    logic [15:0] crc_q;

    // Next CRC value from the clear/enable controls.
    always_comb begin
        // NOTE: default first so every path assigns crc_d and no latch is inferred.
        crc_d = crc_q;
        if (enable) begin
            crc_d = crc16(clear ? 16'h0000 : crc_q, data_in);
        end else if (clear) begin
            crc_d = 16'h0000;
        end
    end

    // CRC register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/dynamixel_status_rx.sv
// Dynamixel 2.0 Status packet receiver: header hunt, byte de-stuffing,
// CRC-16 check and a registered single-cycle result or error strobe.
module dynamixel_status_rx
    import dynamixel_pkg::*;
#(
    parameter int timeout_clocks = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        packet_valid,
    output logic [7:0]  packet_id,
    output logic [7:0]  packet_error,
    output logic [15:0] param_count,
    output logic [31:0] data,
    output logic        crc_error,
    output logic        format_error,
    output logic        timeout
);

    localparam int TO_W = $clog2(timeout_clocks + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_clocks - 1);

    rx_state_e   state_d, state_q;
    logic [15:0] rem_d, rem_q;          // counted bytes left, CRC included
    logic [15:0] len_d, len_q;          // LEN field of the packet in flight
    logic [7:0]  len_lo_d, len_lo_q;
    logic [7:0]  id_acc_d, id_acc_q;
    logic [7:0]  err_acc_d, err_acc_q;
    logic [31:0] data_acc_d, data_acc_q;
    logic [2:0]  idx_d, idx_q;          // de-stuffed param index, saturates at 4
    logic [23:0] hist_d, hist_q;        // last three raw body bytes
    logic [7:0]  crc_lo_d, crc_lo_q;
    logic [TO_W-1:0] to_cnt_d, to_cnt_q;

    logic        packet_valid_d, packet_valid_q;
    logic        crc_error_d, crc_error_q;
    logic        format_error_d, format_error_q;
    logic        timeout_d, timeout_q;
    logic [7:0]  packet_id_d, packet_id_q;
    logic [7:0]  packet_error_d, packet_error_q;
    logic [15:0] param_count_d, param_count_q;
    logic [31:0] data_d, data_q;

    logic        crc_clear;
    logic        crc_en;
    logic [15:0] crc_value;
    logic [15:0] rem_dec;
    logic        stuff_byte;

    dynamixel_crc16 u_crc (
        .clock   (clock),
        .reset   (reset),
        .clear   (crc_clear),
        .enable  (crc_en),
        .data_in (rx_byte),
        .crc     (crc_value)
    );

    // Parser next-state, counters, capture and result/pulse generation.
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        len_d          = len_q;
        len_lo_d       = len_lo_q;
        id_acc_d       = id_acc_q;
        err_acc_d      = err_acc_q;
        data_acc_d     = data_acc_q;
        idx_d          = idx_q;
        hist_d         = hist_q;
        crc_lo_d       = crc_lo_q;
        to_cnt_d       = to_cnt_q;
        packet_valid_d = 1'b0;
        crc_error_d    = 1'b0;
        format_error_d = 1'b0;
        timeout_d      = 1'b0;
        packet_id_d    = packet_id_q;
        packet_error_d = packet_error_q;
        param_count_d  = param_count_q;
        data_d         = data_q;
        crc_clear      = 1'b0;
        crc_en         = 1'b0;

        rem_dec    = rem_q - 16'd1;
        stuff_byte = (state_q == ST_PARAM) && (hist_q == {HDR1, HDR2, HDR3})
                     && (rx_byte == HDR3);

        if (rx_valid) begin
            to_cnt_d = '0;
            case (state_q)
                ST_H1: begin
                    // A fresh FF restarts the CRC with itself as first byte.
                    crc_clear = 1'b1;
                    if (rx_byte == HDR1) begin
                        crc_en  = 1'b1;
                        state_d = ST_H2;
                    end
                end
                ST_H2: begin
                    if (rx_byte == HDR2) begin
                        crc_en  = 1'b1;
                        state_d = ST_H3;
                    end else begin
                        crc_clear = 1'b1;
                        state_d   = ST_H1;
                    end
                end
                ST_H3: begin
                    // Extra FFs keep the last two as the header; CRC already
                    // holds exactly FF FF, so it is left untouched.
                    if (rx_byte == HDR3) begin
                        crc_en  = 1'b1;
                        state_d = ST_RSV;
                    end else if (rx_byte != HDR2) begin
                        crc_clear = 1'b1;
                        state_d   = ST_H1;
                    end
                end
                ST_RSV: begin
                    if (rx_byte == RSV) begin
                        crc_en  = 1'b1;
                        state_d = ST_ID;
                    end else begin
                        format_error_d = 1'b1;
                        crc_clear      = 1'b1;
                        state_d        = ST_H1;
                    end
                end
                ST_ID: begin
                    crc_en   = 1'b1;
                    id_acc_d = rx_byte;
                    hist_d   = '0;
                    state_d  = ST_LEN_L;
                end
                ST_LEN_L: begin
                    crc_en   = 1'b1;
                    len_lo_d = rx_byte;
                    state_d  = ST_LEN_H;
                end
                ST_LEN_H: begin
                    if ({rx_byte, len_lo_q} < 16'd4) begin
                        format_error_d = 1'b1;
                        crc_clear      = 1'b1;
                        state_d        = ST_H1;
                    end else begin
                        crc_en  = 1'b1;
                        rem_d   = {rx_byte, len_lo_q};
                        len_d   = {rx_byte, len_lo_q};
                        state_d = ST_INSTR;
                    end
                end
                ST_INSTR: begin
                    if (rx_byte != INST_STATUS) begin
                        format_error_d = 1'b1;
                        crc_clear      = 1'b1;
                        state_d        = ST_H1;
                    end else begin
                        crc_en  = 1'b1;
                        rem_d   = rem_dec;
                        hist_d  = {hist_q[15:0], rx_byte};
                        state_d = ST_ERR;
                    end
                end
                ST_ERR: begin
                    crc_en     = 1'b1;
                    err_acc_d  = rx_byte;
                    rem_d      = rem_dec;
                    hist_d     = {hist_q[15:0], rx_byte};
                    data_acc_d = '0;
                    idx_d      = '0;
                    state_d    = (rem_dec == 16'd2) ? ST_CRC_L : ST_PARAM;
                end
                ST_PARAM: begin
                    crc_en = 1'b1;
                    if (stuff_byte) begin
                        // Stuffing FD: covered by the CRC, otherwise invisible.
                        hist_d = '0;
                    end else begin
                        rem_d  = rem_dec;
                        hist_d = {hist_q[15:0], rx_byte};
                        if (idx_q < 3'd4) begin
                            data_acc_d[{idx_q[1:0], 3'b000} +: 8] = rx_byte;
                            idx_d = idx_q + 3'd1;
                        end
                        if (rem_dec == 16'd2) begin
                            state_d = ST_CRC_L;
                        end
                    end
                end
                ST_CRC_L: begin
                    crc_lo_d = rx_byte;
                    state_d  = ST_CRC_H;
                end
                ST_CRC_H: begin
                    crc_clear = 1'b1;
                    state_d   = ST_H1;
                    if ({rx_byte, crc_lo_q} == crc_value) begin
                        packet_valid_d = 1'b1;
                        packet_id_d    = id_acc_q;
                        packet_error_d = err_acc_q;
                        param_count_d  = len_q - 16'd4;
                        data_d         = data_acc_q;
                    end else begin
                        crc_error_d = 1'b1;
                    end
                end
                default: begin
                    crc_clear = 1'b1;
                    state_d   = ST_H1;
                end
            endcase
        end else if (state_q != ST_H1) begin
            // A byte in the same cycle always wins, so only idle cycles count.
            if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                crc_clear = 1'b1;
                to_cnt_d  = '0;
                state_d   = ST_H1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_H1;
            rem_q          <= '0;
            len_q          <= '0;
            len_lo_q       <= '0;
            id_acc_q       <= '0;
            err_acc_q      <= '0;
            data_acc_q     <= '0;
            idx_q          <= '0;
            hist_q         <= '0;
            crc_lo_q       <= '0;
            to_cnt_q       <= '0;
            packet_valid_q <= 1'b0;
            crc_error_q    <= 1'b0;
            format_error_q <= 1'b0;
            timeout_q      <= 1'b0;
            packet_id_q    <= '0;
            packet_error_q <= '0;
            param_count_q  <= '0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            len_q          <= len_d;
            len_lo_q       <= len_lo_d;
            id_acc_q       <= id_acc_d;
            err_acc_q      <= err_acc_d;
            data_acc_q     <= data_acc_d;
            idx_q          <= idx_d;
            hist_q         <= hist_d;
            crc_lo_q       <= crc_lo_d;
            to_cnt_q       <= to_cnt_d;
            packet_valid_q <= packet_valid_d;
            crc_error_q    <= crc_error_d;
            format_error_q <= format_error_d;
            timeout_q      <= timeout_d;
            packet_id_q    <= packet_id_d;
            packet_error_q <= packet_error_d;
            param_count_q  <= param_count_d;
            data_q         <= data_d;
        end
    end

    assign packet_valid = packet_valid_q;
    assign crc_error    = crc_error_q;
    assign format_error = format_error_q;
    assign timeout      = timeout_q;
    assign packet_id    = packet_id_q;
    assign packet_error = packet_error_q;
    assign param_count  = param_count_q;
    assign data         = data_q;

endmodule

// File: tb/tb_dynamixel_status_rx.sv
// Scoreboard bench for dynamixel_status_rx: stimulus pushes expected
// strobes, a negedge monitor pops and compares whenever a strobe appears.
module tb_dynamixel_status_rx;

    typedef logic [7:0] bq_t [$];

    typedef struct packed {
        logic [3:0]  kind;   // {valid, crc_error, format_error, timeout}
        logic [7:0]  id;
        logic [7:0]  err;
        logic [15:0] pc;
        logic [31:0] data;
    } exp_t;

    localparam logic [3:0] K_VALID = 4'b1000;
    localparam logic [3:0] K_CRC   = 4'b0100;
    localparam logic [3:0] K_FMT   = 4'b0010;
    localparam logic [3:0] K_TO    = 4'b0001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        packet_valid;
    logic [7:0]  packet_id;
    logic [7:0]  packet_error;
    logic [15:0] param_count;
    logic [31:0] data;
    logic        crc_error;
    logic        format_error;
    logic        timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t last_good;

    always #5 clock = ~clock;

    dynamixel_status_rx #(.timeout_clocks(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .packet_valid (packet_valid),
        .packet_id    (packet_id),
        .packet_error (packet_error),
        .param_count  (param_count),
        .data         (data),
        .crc_error    (crc_error),
        .format_error (format_error),
        .timeout      (timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC, fed one input bit at a time.
    function automatic logic [15:0] model_crc(input bq_t b);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    function automatic bq_t with_crc(input bq_t b);
        bq_t r;
        logic [15:0] c;
        c = model_crc(b);
        r = b;
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
        return r;
    endfunction

    task automatic send(input bq_t b);
        foreach (b[i]) begin
            @(posedge clock); #1;
            rx_valid = 1'b1;
            rx_byte  = b[i];
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic exp_good(input logic [7:0] id, input logic [7:0] err,
                            input logic [15:0] pc, input logic [31:0] d);
        exp_t e;
        e.kind = K_VALID;
        e.id   = id;
        e.err  = err;
        e.pc   = pc;
        e.data = d;
        sb.push_back(e);
        last_good = e;
    endtask

    task automatic exp_bad(input logic [3:0] k);
        exp_t e;
        e      = last_good;
        e.kind = k;
        sb.push_back(e);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pulses"}, {packet_valid, crc_error, format_error, timeout}, 4'b0000);
        check({tag, "_id"},     packet_id,    8'h00);
        check({tag, "_err"},    packet_error, 8'h00);
        check({tag, "_pcount"}, param_count,  16'h0000);
        check({tag, "_data"},   data,         32'h0);
    endtask

    // Monitor: any strobe must match the head of the scoreboard.
    always @(negedge clock) begin : monitor
        logic [3:0] pulses;
        exp_t       e;
        pulses = {packet_valid, crc_error, format_error, timeout};
        if (pulses != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {60'b0, pulses}, 64'h0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind",   pulses,       e.kind);
                check("packet_id",    packet_id,    e.id);
                check("packet_error", packet_error, e.err);
                check("param_count",  param_count,  e.pc);
                check("data",         data,         e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t ping, ping_a, ping_b, rd, rd_bad, pkt;

        ping   = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55,
                  8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        ping_a = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01};
        ping_b = {8'h07, 8'h00, 8'h55, 8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        rd     = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55,
                  8'h00, 8'hA6, 8'h00, 8'h00, 8'h00, 8'h8C, 8'hC0};
        rd_bad = {8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55,
                  8'h00, 8'hA6, 8'h00, 8'h00, 8'h00, 8'h8C, 8'hC1};
        last_good = '0;

        idle(3); #1;
        reset = 1'b0;
        @(negedge clock);
        check_zero_outputs("reset");

        // Ping status.
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send(ping);

        // Read status, four parameters.
        exp_good(8'h01, 8'h00, 16'd4, 32'h0000_00A6);
        send(rd);

        // Corrupted CRC, then a ping back-to-back with no recovery gap.
        exp_bad(K_CRC);
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send({rd_bad, ping});

        // Garbage and false headers ahead of a ping.
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send({8'h00, 8'hFF, 8'h12, 8'h00, 8'hFF, ping});

        // Stuffed param field FF FF FD FD FD -> FF FF FD FD; LEN counts de-stuffed bytes.
        pkt = with_crc({8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55,
                        8'h00, 8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'hFD});
        exp_good(8'h01, 8'h00, 16'd4, 32'hFDFD_FFFF);
        send(pkt);

        // LEN=4: no parameters, data cleared.
        pkt = with_crc({8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h07, 8'h04, 8'h00, 8'h55, 8'h2A});
        exp_good(8'h07, 8'h2A, 16'd0, 32'h0);
        send(pkt);

        // Six parameters: only the first four are kept.
        pkt = with_crc({8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h03, 8'h0A, 8'h00, 8'h55,
                        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        exp_good(8'h03, 8'h00, 16'd6, 32'h4433_2211);
        send(pkt);

        // Bad instruction byte.
        exp_bad(K_FMT);
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send({8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h56, ping});

        // LEN below the minimum.
        exp_bad(K_FMT);
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send({8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00, ping});

        // Bad reserved byte.
        exp_bad(K_FMT);
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send({8'hFF, 8'hFF, 8'hFD, 8'h01, ping});

        // 15 idle clocks after the ID byte: one short of the limit, packet survives.
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send(ping_a);
        idle(14);
        send(ping_b);

        // 16 idle clocks after the ID byte: timeout, then the next byte is seen in H1.
        exp_bad(K_TO);
        send(ping_a);
        idle(15);
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send(ping);

        // Reset mid-packet, with a byte presented in the reset cycle.
        send({8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07});
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h00;
        @(posedge clock); #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clock);
        check_zero_outputs("mid_reset");
        last_good = '0;
        exp_good(8'h01, 8'h00, 16'd3, 32'h0026_0406);
        send(ping);

        idle(5);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clock);
        check("scoreboard_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
